uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// ---------------------------------------------------------------------------
// PURPOSE
//  Frame controller for the UART transmitter.
//  - Accepts one parallel byte per frame and sequences start, data (LSB first),
//    optional parity and stop bits onto TX_OUT, one bit per CLK (CLK = baud tick).
//  - Owns the handshake to the parity calculator: generates its qualified
//    valid strobe and inserts its par_bit into the frame.
//  - Sits between the host byte interface and the serial line pin.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame
//  STOP_BITS   1  stop bits per frame; legal values 1 or 2
// PORTS
//  CLK          in   1           baud-rate clock; all logic on rising edge
//  RST          in   1           synchronous, active-high reset
//  P_DATA       in   DATA_WIDTH  byte to send; sampled only on accept
//  Data_valid   in   1           host request; accepted only in IDLE
//  PAR_EN       in   1           1 = insert parity bit; sampled on accept
//  PAR_TYP      in   1           0 = even, 1 = odd; sampled on accept
//  par_bit      in   1           parity bit from the parity calculator
//  par_valid    out  1           qualified valid to parity calculator (comb.)
//  TX_OUT       out  1           serial line, idle high (registered)
//  busy         out  1           frame in progress (registered)
// BEHAVIOUR
//  - Reset: state=IDLE, TX_OUT=1, busy=0, bit_cnt=0, shift reg=0,
//    latched PAR_EN=0 and PAR_TYP=0. par_valid=0 while RST=1.
//    RST asserted mid-frame aborts the frame. On the next edge TX_OUT=1 and
//    busy=0; no partial bits follow.
//  - Accept: Data_valid=1 && state==IDLE && !RST in cycle N.
//    - Latches P_DATA, PAR_EN and PAR_TYP.
//    - par_valid = Data_valid & (state==IDLE), same cycle N, so the
//      calculator latches parity on the same byte.
//    - Data_valid while busy is ignored. It is not queued and par_valid stays 0.
//  - Timing: accept in cycle N gives TX_OUT=0 (start bit) and busy=1 from N+1.
//    Frame length F = 1 + DATA_WIDTH + PAR_EN + STOP_BITS cycles.
//    busy=1 for exactly cycles N+1..N+F. busy=0 and TX_OUT=1 at N+F+1.
//  - States and transitions:
//    - IDLE: TX_OUT=1. On accept go to START.
//    - START: one cycle, TX_OUT=0. Go to DATA with bit_cnt=0.
//    - DATA: TX_OUT = shreg[0], then shift right. bit_cnt increments each cycle.
//      When bit_cnt==DATA_WIDTH-1, go to PARITY if PAR_EN latched, else STOP.
//    - PARITY: one cycle, TX_OUT = par_bit. Go to STOP.
//    - STOP: STOP_BITS cycles, TX_OUT=1. Then return to IDLE.
//  - The earliest next accept is the IDLE cycle N+F+1, so the line idles at
//    least 1 cycle between frames.
//  - bit_cnt width is $clog2(DATA_WIDTH)+1. It resets to 0 on every START and
//    never wraps mid-frame.
//  - Simultaneous RST and Data_valid: RST wins and nothing is accepted.
// TESTING
//  1. RST=1 for 3 cycles, then release -> TX_OUT=1, busy=0, par_valid=0.
//  2. P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, Data_valid 1 cycle
//     -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1; busy high for 11 cycles.
//  3. P_DATA=8'h07, PAR_EN=1, PAR_TYP=1 -> parity slot = 0.
//     Repeat with PAR_TYP=0 -> parity slot = 1.
//  4. P_DATA=8'hFF, PAR_EN=0, STOP_BITS=2 -> 0, eight 1s, 1, 1.
//     busy high for 11 cycles; par_valid pulses only on the accept cycle.
//  5. Data_valid held high with P_DATA=8'h3C then 8'hC3
//     -> 8'h3C frame sent; changes during busy are ignored.
//     The next accept is in the first IDLE cycle.
//  6. RST pulsed during DATA bit 4 of 8'h55
//     -> next cycle TX_OUT=1, busy=0; a new Data_valid starts a clean frame.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART frame controller: start, LSB-first data, optional parity, stop bit(s) on TX_OUT.
// Latency: accept in cycle N puts the start bit on TX_OUT in N+1, one bit per CLK.
// Backpressure: Data_valid is only taken in IDLE; requests while busy are dropped, not queued.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  par_bit,
  output logic                  par_valid,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         bit_cnt;
  logic [1:0]            stop_cnt;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  accept;

  // Accept qualifier; the parity calculator sees the same strobe so it latches the same byte.
  always_comb begin
    accept    = Data_valid && (state == IDLE) && !RST;
    par_valid = accept;
  end

  // Frame sequencer; TX_OUT is registered, so each branch loads the bit for the next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          if (accept) begin
            shreg     <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            TX_OUT    <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          TX_OUT  <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
            stop_cnt <= '0;
            if (par_en_q) begin
              TX_OUT <= par_bit;
              state  <= PARITY;
            end else begin
              TX_OUT <= 1'b1;
              state  <= STOP;
            end
          end else begin
            TX_OUT  <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          TX_OUT   <= 1'b1;
          stop_cnt <= '0;
          state    <= STOP;
        end
        STOP: begin
          TX_OUT <= 1'b1;
          if (stop_cnt == 2'(STOP_BITS - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one-stop-bit and two-stop-bit instances.
// Inputs driven 1 time unit after the rising edge; outputs checked there too.
// Includes a behavioural parity calculator that latches on par_valid.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_valid, Data_valid2;
  logic       PAR_EN, PAR_TYP;
  logic       par_bit, par_bit2;
  logic       par_valid, par_valid2;
  logic       TX_OUT, TX_OUT2;
  logic       busy, busy2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_valid(Data_valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .par_bit(par_bit),
    .par_valid(par_valid), .TX_OUT(TX_OUT), .busy(busy)
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_valid(Data_valid2),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .par_bit(par_bit2),
    .par_valid(par_valid2), .TX_OUT(TX_OUT2), .busy(busy2)
  );

  // Parity calculator models: latch even/odd parity of the byte on the strobe.
  always @(posedge CLK) begin
    if (RST) begin
      par_bit  <= 1'b0;
      par_bit2 <= 1'b0;
    end else begin
      if (par_valid)  par_bit  <= (^P_DATA) ^ PAR_TYP;
      if (par_valid2) par_bit2 <= (^P_DATA) ^ PAR_TYP;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic sel_tx(input int sel);
    return (sel == 2) ? TX_OUT2 : TX_OUT;
  endfunction
  function automatic logic sel_busy(input int sel);
    return (sel == 2) ? busy2 : busy;
  endfunction
  function automatic logic sel_pv(input int sel);
    return (sel == 2) ? par_valid2 : par_valid;
  endfunction

  // Called in the accept cycle with inputs already driven. frame bit i is TX_OUT in cycle N+1+i.
  // hold keeps the request asserted and swaps in nd after accept. Returns in cycle N+F+1.
  task automatic run_frame(input string tag, input int sel, input logic [15:0] frame,
                           input int f, input bit hold, input logic [7:0] nd);
    chk({tag, "_pv_accept"}, sel_pv(sel), 1'b1);
    step();
    if (hold) P_DATA = nd;
    else begin
      Data_valid  = 1'b0;
      Data_valid2 = 1'b0;
    end
    for (int i = 0; i < f; i++) begin
      chk($sformatf("%s_tx%0d", tag, i), sel_tx(sel), frame[i]);
      chk($sformatf("%s_busy%0d", tag, i), sel_busy(sel), 1'b1);
      chk($sformatf("%s_pv%0d", tag, i), sel_pv(sel), 1'b0);
      step();
    end
    chk({tag, "_idle_tx"}, sel_tx(sel), 1'b1);
    chk({tag, "_idle_busy"}, sel_busy(sel), 1'b0);
  endtask

  initial begin
    RST = 1'b1; P_DATA = 8'h00; Data_valid = 1'b0; Data_valid2 = 1'b0;
    PAR_EN = 1'b0; PAR_TYP = 1'b0;

    // 1: reset for 3 cycles
    step(); step(); step();
    chk("rst_pv", par_valid, 1'b0);
    RST = 1'b0;
    step();
    chk("rst_tx", TX_OUT, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pv_rel", par_valid, 1'b0);
    chk("rst_tx2", TX_OUT2, 1'b1);
    chk("rst_busy2", busy2, 1'b0);

    // 2: A5 even parity -> 0,1,0,1,0,0,1,0,1,0,1
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_valid = 1'b1;
    #1;
    run_frame("a5_even", 1, 16'b00000_10101001010, 11, 1'b0, 8'h00);
    step();

    // 3: 07 odd -> parity 0, even -> parity 1
    P_DATA = 8'h07; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_valid = 1'b1;
    #1;
    run_frame("07_odd", 1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0, 8'h00);
    P_DATA = 8'h07; PAR_TYP = 1'b0; Data_valid = 1'b1;
    #1;
    run_frame("07_even", 1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0, 8'h00);

    // 4: FF, no parity, two stop bits
    P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_valid2 = 1'b1;
    #1;
    run_frame("ff_2stop", 2, {5'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11, 1'b0, 8'h00);
    step();
    chk("ff_2stop_pv_after", par_valid2, 1'b0);

    // 5: request held high; data changes during busy are ignored, next accept on first IDLE
    P_DATA = 8'h3C; PAR_EN = 1'b0; Data_valid = 1'b1;
    #1;
    run_frame("3c_held", 1, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 1'b1, 8'hC3);
    run_frame("c3_next", 1, {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 1'b0, 8'h00);

    // 6: reset during DATA bit 4 of 55
    P_DATA = 8'h55; PAR_EN = 1'b0; Data_valid = 1'b1;
    #1;
    chk("55_pv_accept", par_valid, 1'b1);
    step();
    Data_valid = 1'b0;
    chk("55_start", TX_OUT, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("55_bit4", TX_OUT, 1'b1);
    chk("55_bit4_busy", busy, 1'b1);
    RST = 1'b1;
    step();
    chk("55_abort_tx", TX_OUT, 1'b1);
    chk("55_abort_busy", busy, 1'b0);
    // RST and Data_valid together: nothing accepted
    Data_valid = 1'b1;
    #1;
    chk("rst_dv_pv", par_valid, 1'b0);
    step();
    chk("rst_dv_busy", busy, 1'b0);
    chk("rst_dv_tx", TX_OUT, 1'b1);
    chk("rst_dv_pv2", par_valid, 1'b0);
    step();
    chk("rst_dv_busy2", busy, 1'b0);
    // Clean frame after reset: 55 even parity -> parity 0
    RST = 1'b0; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    #1;
    run_frame("55_clean", 1, {5'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
